timer_off_delay: RTL and testbench
==================================

// Module: timer_off_delay
// PURPOSE
//  Ladder-logic TOF (off-delay timer), the counterpart of the on-delay timer block. DN rises as soon as the
//  rung (IN) goes true. After IN falls, DN stays high until PRE ms have elapsed, then drops.
//  Counts the shared 1 kHz down-sampled tick. Sits beside the TON in the generated rung logic.
// PARAMETERS
//  W  32  width of PRE and ACC in bits
// PORTS
//  clk  in   1  system clock; the only clock
//  rst  in   1  synchronous reset, active-high
//  tick in   1  1 kHz down-sampled clock; each rising edge is 1 ms; async to nothing (same clk domain)
//  PRE  in   W  preset, ms to hold DN after IN falls
//  IN   in   1  rung condition (timer enable)
//  DN   out  1  done/hold output: 1 while IN=1 or while off-delay is running
//  TT   out  1  timer timing: 1 while IN=0 and off-delay is counting
//  EN   out  1  registered copy of IN
//  ACC  out  W  accumulated ms since IN fell; saturates at PRE
// BEHAVIOUR
//  - One clock domain. Reset is synchronous and active-high: rst=1 at posedge clk resets the block.
//  - Reset: state=S_IDLE, ACC=0, DN=0, TT=0, EN=0, last_tick=0. rst has priority over every other input.
//  - All outputs are registered. A change on IN sampled at edge n is visible after edge n.
//  - Tick edge: tick_rise = tick & ~last_tick. last_tick <= tick on every non-reset clk.
//  - Outputs per state:
//      S_IDLE:   DN=0, TT=0, EN=0; ACC holds its last value (0 after reset, else the final count).
//      S_ON:     DN=1, TT=0, EN=1; ACC=0.
//      S_TIMING: DN=1, TT=1, EN=0; ACC counts.
//  - Transitions, evaluated every clk:
//      S_IDLE:   IN=1 -> S_ON, ACC<=0.
//      S_ON:     IN=0 & PRE==0 -> S_IDLE (DN falls with no delay).
//                IN=0 & PRE!=0 -> S_TIMING, ACC stays 0.
//      S_TIMING: IN=1 -> S_ON, ACC<=0. IN wins over a simultaneous tick_rise.
//                else if ACC>=PRE -> S_IDLE, ACC unchanged. Covers PRE lowered mid-count.
//                else if tick_rise: ACC<=ACC+1; if ACC+1>=PRE -> S_IDLE (DN/TT fall on the same edge).
//  - ACC never exceeds max(PRE at time of count, 0) and never wraps. Comparisons are unsigned, W bits.
//  - tick_rise is ignored outside S_TIMING. The first ms may be partial (count starts at the next tick edge).
//  - PRE is sampled live every clk. There is no latching.
//  - rst mid-count: the next cycle is exactly the reset state. An IN=1 held through reset -> S_ON one clk after release.
//  - Unreachable state encodings -> S_IDLE.
// CONFIGURATION
//  TOF_RES_EN defined: adds input RES (1 bit), a ladder RES instruction. RES=1 forces ACC<=0, DN<=0, TT<=0, state<=S_IDLE.
//    EN still tracks IN. Priority: rst > RES > normal FSM.
//    When RES releases with IN=1, the block enters S_ON on the next clk.
//  TOF_RES_EN undefined: RES port is absent; behaviour is exactly as above.
// TESTING
//  1. rst=1 for 2 clk, IN=0 -> DN=TT=EN=0, ACC=0; 10 ticks produce no change.
//  2. PRE=5, IN 0->1 -> next clk DN=1, EN=1, TT=0, ACC=0.
//     Then IN->0: TT=1 and DN=1 through ticks 1-4 (ACC 1..4).
//     On the 5th tick edge ACC=5, DN=0, TT=0. ACC stays 5 through further ticks.
//  3. PRE=5, IN falls, 3 ticks (ACC=3), then IN=1 on the same clk as a tick edge -> ACC=0, DN=1, TT=0 (IN wins).
//  4. PRE=0, IN 1->0 -> DN=0 one clk later, TT never 1, ACC=0.
//  5. PRE=10, IN falls, ACC reaches 7, then PRE->4 -> next clk state S_IDLE, DN=0, TT=0, ACC=7.
//     Also: rst asserted at ACC=3 -> all outputs 0 on the next clk.
//  6. (TOF_RES_EN) PRE=8, ACC=4 timing, RES=1 for 1 clk -> ACC=0, DN=0, TT=0.
//     RES=1 with IN=1 -> EN=1, DN=0; RES released -> DN=1 next clk.

Source files
------------

// File: rtl/timer_off_delay.sv
// timer_off_delay: ladder-logic TOF (off-delay) timer.
// DN rises as soon as IN is true and, once IN falls, is held for PRE ms
// counted on the shared 1 kHz tick.
// Optional feature macro: TOF_RES_EN adds the RES (reset instruction) input.
module timer_off_delay #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
`ifdef TOF_RES_EN
  input  logic         RES,
`endif
  input  logic [W-1:0] PRE,
  input  logic         IN,
  output logic         DN,
  output logic         TT,
  output logic         EN,
  output logic [W-1:0] ACC
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ON     = 2'b01,
    S_TIMING = 2'b10
  } state_t;

  localparam logic [W-1:0] ACC_ZERO = {W{1'b0}};
  localparam logic [W-1:0] ACC_ONE  = {{(W-1){1'b0}}, 1'b1};

  state_t       state_r;
  state_t       state_nxt_s;
  logic [W-1:0] acc_r;
  logic [W-1:0] acc_nxt_s;
  logic [W-1:0] acc_inc_s;
  logic         last_tick_r;
  logic         tick_rise_s;
  logic         dn_r;
  logic         tt_r;
  logic         en_r;
  logic         res_s;

`ifdef TOF_RES_EN
  assign res_s = RES;
`else
  assign res_s = 1'b0;
`endif

  // A count can only advance when acc_r < PRE, so the increment never wraps.
  assign tick_rise_s = tick & ~last_tick_r;
  assign acc_inc_s   = acc_r + ACC_ONE;

  // Next-state and next-accumulator decode; RES overrides the normal FSM.
  always_comb begin
    state_nxt_s = state_r;
    acc_nxt_s   = acc_r;
    if (res_s) begin
      state_nxt_s = S_IDLE;
      acc_nxt_s   = ACC_ZERO;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (IN) begin
            state_nxt_s = S_ON;
            acc_nxt_s   = ACC_ZERO;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_ON: begin
          acc_nxt_s = ACC_ZERO;
          if (!IN) begin
            if (PRE == ACC_ZERO) begin
              state_nxt_s = S_IDLE;
            end else begin
              state_nxt_s = S_TIMING;
            end
          end else begin
            state_nxt_s = S_ON;
          end
        end
        S_TIMING: begin
          if (IN) begin
            state_nxt_s = S_ON;
            acc_nxt_s   = ACC_ZERO;
          end else if (acc_r >= PRE) begin
            // PRE lowered below the running count: stop, keep the count.
            state_nxt_s = S_IDLE;
          end else if (tick_rise_s) begin
            acc_nxt_s = acc_inc_s;
            if (acc_inc_s >= PRE) begin
              state_nxt_s = S_IDLE;
            end else begin
              state_nxt_s = S_TIMING;
            end
          end else begin
            state_nxt_s = S_TIMING;
          end
        end
        default: begin
          state_nxt_s = S_IDLE;
        end
      endcase
    end
  end

  // State, accumulator and registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      acc_r       <= ACC_ZERO;
      last_tick_r <= 1'b0;
      dn_r        <= 1'b0;
      tt_r        <= 1'b0;
      en_r        <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      last_tick_r <= tick;
      dn_r        <= (state_nxt_s != S_IDLE);
      tt_r        <= (state_nxt_s == S_TIMING);
      en_r        <= IN;
    end
  end

  assign DN  = dn_r;
  assign TT  = tt_r;
  assign EN  = en_r;
  assign ACC = acc_r;

endmodule

// File: tb/tb_timer_off_delay.sv
// Testbench for timer_off_delay: directed scenarios plus randomized stimulus
// checked every clock against a behavioural off-delay model.
module tb_timer_off_delay;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         tick;
  logic [W-1:0] PRE;
  logic         IN;
  logic         DN;
  logic         TT;
  logic         EN;
  logic [W-1:0] ACC;
`ifdef TOF_RES_EN
  logic         RES;
`endif

  int checks;
  int errors;

  // Behavioural model: "held" = rung true, "delay" = off-delay in progress.
  bit              m_held;
  bit              m_delay;
  longint unsigned m_ms;
  bit              m_prev_tick;
  bit              m_en;

  timer_off_delay #(.W(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
`ifdef TOF_RES_EN
    .RES  (RES),
`endif
    .PRE  (PRE),
    .IN   (IN),
    .DN   (DN),
    .TT   (TT),
    .EN   (EN),
    .ACC  (ACC)
  );

  // 100 MHz-style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_clock();
    bit              res_v;
    bit              new_ms;
    longint unsigned preset;
    res_v = 1'b0;
`ifdef TOF_RES_EN
    res_v = RES;
`endif
    preset = longint'(PRE);
    if (rst) begin
      m_held = 0; m_delay = 0; m_ms = 0; m_prev_tick = 0; m_en = 0;
    end else begin
      new_ms      = tick && !m_prev_tick;
      m_prev_tick = tick;
      m_en        = IN;
      if (res_v) begin
        m_held = 0; m_delay = 0; m_ms = 0;
      end else if (IN) begin
        // Rung true: output held, elapsed time cleared.
        m_held = 1; m_delay = 0; m_ms = 0;
      end else if (m_held) begin
        // Rung just fell: start the delay unless there is nothing to wait for.
        m_held  = 0;
        m_delay = (preset != 0);
      end else if (m_delay) begin
        if (m_ms >= preset) m_delay = 0;
        else if (new_ms) begin
          m_ms = m_ms + 1;
          if (m_ms >= preset) m_delay = 0;
        end
      end
    end
  endtask

  // One clock: update the model at the edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check("DN",  DN,  m_held | m_delay);
    check("TT",  TT,  m_delay);
    check("EN",  EN,  m_en);
    check("ACC", ACC, m_ms);
  endtask

  task automatic do_tick();
    tick = 1'b1; step();
    tick = 1'b0; step();
  endtask

  initial begin
    checks = 0; errors = 0;
    m_held = 0; m_delay = 0; m_ms = 0; m_prev_tick = 0; m_en = 0;
    rst = 1'b1; tick = 1'b0; PRE = 32'd5; IN = 1'b0;
`ifdef TOF_RES_EN
    RES = 1'b0;
`endif

    // 1: reset, then ticks with IN low change nothing
    step(); step();
    check("rst_DN", DN, 1'b0); check("rst_TT", TT, 1'b0);
    check("rst_EN", EN, 1'b0); check("rst_ACC", ACC, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) do_tick();
    check("idle_DN", DN, 1'b0); check("idle_ACC", ACC, 32'd0);

    // 2: PRE=5 full off-delay
    PRE = 32'd5; IN = 1'b1; step();
    check("on_DN", DN, 1'b1); check("on_EN", EN, 1'b1);
    check("on_TT", TT, 1'b0); check("on_ACC", ACC, 32'd0);
    IN = 1'b0; step();
    check("tm_TT", TT, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      do_tick();
      check("tm_ACC", ACC, 32'(i)); check("tm_DN", DN, 1'b1);
    end
    tick = 1'b1; step();
    check("done_ACC", ACC, 32'd5); check("done_DN", DN, 1'b0); check("done_TT", TT, 1'b0);
    tick = 1'b0; step();
    do_tick(); do_tick();
    check("sat_ACC", ACC, 32'd5);

    // 3: IN wins over a simultaneous tick edge
    IN = 1'b1; step(); IN = 1'b0; step();
    for (int i = 0; i < 3; i++) do_tick();
    check("t3_ACC", ACC, 32'd3);
    tick = 1'b1; IN = 1'b1; step();
    check("t3_win_ACC", ACC, 32'd0); check("t3_win_DN", DN, 1'b1); check("t3_win_TT", TT, 1'b0);
    tick = 1'b0; step();

    // 4: PRE=0 drops DN with no delay
    PRE = 32'd0; IN = 1'b1; step(); IN = 1'b0; step();
    check("p0_DN", DN, 1'b0); check("p0_TT", TT, 1'b0); check("p0_ACC", ACC, 32'd0);

    // 5: PRE lowered mid-count, then reset mid-count
    PRE = 32'd10; IN = 1'b1; step(); IN = 1'b0; step();
    for (int i = 0; i < 7; i++) do_tick();
    PRE = 32'd4; step();
    check("lower_DN", DN, 1'b0); check("lower_TT", TT, 1'b0); check("lower_ACC", ACC, 32'd7);
    PRE = 32'd10; IN = 1'b1; step(); IN = 1'b0; step();
    for (int i = 0; i < 3; i++) do_tick();
    rst = 1'b1; step();
    check("mid_rst_DN", DN, 1'b0); check("mid_rst_TT", TT, 1'b0); check("mid_rst_ACC", ACC, 32'd0);
    rst = 1'b0; step();

`ifdef TOF_RES_EN
    // 6: RES instruction
    PRE = 32'd8; IN = 1'b1; step(); IN = 1'b0; step();
    for (int i = 0; i < 4; i++) do_tick();
    RES = 1'b1; step();
    check("res_ACC", ACC, 32'd0); check("res_DN", DN, 1'b0); check("res_TT", TT, 1'b0);
    IN = 1'b1; step();
    check("res_in_EN", EN, 1'b1); check("res_in_DN", DN, 1'b0);
    RES = 1'b0; step();
    check("res_rel_DN", DN, 1'b1);
`endif

    // Randomized phase
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) < 3) IN = ~IN;
      if ($urandom_range(0, 2) == 0) tick = ~tick;
      if ($urandom_range(0, 199) == 0) begin
        if ($urandom_range(0, 9) == 0) PRE = 32'hFFFF_FFFF;
        else PRE = 32'($urandom_range(0, 12));
      end
      rst = ($urandom_range(0, 699) == 0);
`ifdef TOF_RES_EN
      RES = ($urandom_range(0, 399) == 0);
`endif
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
